// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - retriggerable one-shot interval timer
// Emits a one-cycle done pulse INTERVAL_CYCLES edges after the last sampled start.
module interval_timer #(
  parameter int INTERVAL_CYCLES = 8,
  localparam int CNT_W = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERVAL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        cnt_d   = RELOAD;
        state_d = RUN;
      end
    end else if (cnt_q != '0) begin
      cnt_d = start ? RELOAD : cnt_q - CNT_W'(1);
    end else begin
      // Expiry edge: a coincident start chains straight into the next interval.
      done_d = 1'b1;
      if (start) begin
        cnt_d = RELOAD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign remaining = cnt_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer
// Two instances: default interval of 8 and the single-cycle boundary case.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic       start1 = 1'b0;
  logic       done8, busy8, done1, busy1;
  logic [2:0] rem8;
  logic [0:0] rem1;

  int checks = 0;
  int errors = 0;

  interval_timer #(.INTERVAL_CYCLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .done(done8), .busy(busy8), .remaining(rem8)
  );

  interval_timer #(.INTERVAL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .done(done1), .busy(busy1), .remaining(rem1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    sel;
    bit    rst;
    bit    st;
    bit    ed;
    bit    eb;
    int    er;
    string tag;
  } vec_t;

  typedef struct {
    bit    sel;
    bit    ed;
    bit    eb;
    int    er;
    string tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic void add(bit sel, bit rst, bit st, bit ed, bit eb, int er, string tag);
    vec_t v;
    v.sel = sel; v.rst = rst; v.st = st; v.ed = ed; v.eb = eb; v.er = er; v.tag = tag;
    tbl.push_back(v);
  endfunction

  task automatic compare_head();
    exp_t e;
    bit   d, b;
    int   r;
    e = sb.pop_front();
    d = e.sel ? done1 : done8;
    b = e.sel ? busy1 : busy8;
    r = e.sel ? int'(rem1) : int'(rem8);
    checks++;
    if (d !== e.ed || b !== e.eb || r != e.er) begin
      errors++;
      $display("FAIL %s: got done=%0b busy=%0b remaining=%0d, want done=%0b busy=%0b remaining=%0d",
               e.tag, d, b, r, e.ed, e.eb, e.er);
    end
  endtask

  task automatic push_exp(bit sel, bit ed, bit eb, int er, string tag);
    exp_t e;
    e.sel = sel; e.ed = ed; e.eb = eb; e.er = er; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive inputs away from the edge, then compare just after the edge.
  task automatic step(bit sel, bit rst, bit st, bit ed, bit eb, int er, string tag);
    @(negedge clk);
    rst_n  = rst;
    start8 = sel ? 1'b0 : st;
    start1 = sel ? st : 1'b0;
    push_exp(sel, ed, eb, er, tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    int n;
    bit seen;

    // Reset and idle after release
    add(0, 0, 0, 0, 0, 0, "reset8");
    add(1, 0, 0, 0, 0, 0, "reset1");
    add(0, 1, 0, 0, 0, 0, "idle_a");
    add(0, 1, 0, 0, 0, 0, "idle_b");
    // Single shot
    add(0, 1, 1, 0, 1, 7, "shot_k");
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 0, 1, i, "shot_cnt");
    add(0, 1, 0, 1, 0, 0, "shot_done");
    add(0, 1, 0, 0, 0, 0, "shot_after");
    // Retrigger at k+3
    add(0, 1, 1, 0, 1, 7, "retrig_k");
    add(0, 1, 0, 0, 1, 6, "retrig_k1");
    add(0, 1, 0, 0, 1, 5, "retrig_k2");
    add(0, 1, 1, 0, 1, 7, "retrig_k3");
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 0, 1, i, "retrig_cnt");
    add(0, 1, 0, 1, 0, 0, "retrig_done");
    add(0, 1, 0, 0, 0, 0, "retrig_after");
    // Back-to-back on the expiry edge
    add(0, 1, 1, 0, 1, 7, "b2b_k");
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 0, 1, i, "b2b_cnt1");
    add(0, 1, 1, 1, 1, 7, "b2b_k8");
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 0, 1, i, "b2b_cnt2");
    add(0, 1, 0, 1, 0, 0, "b2b_k16");
    add(0, 1, 0, 0, 0, 0, "b2b_after");
    // INTERVAL_CYCLES=1: single shot, then start held for 4 cycles
    add(1, 1, 1, 0, 1, 0, "one_k");
    add(1, 1, 0, 1, 0, 0, "one_done");
    add(1, 1, 0, 0, 0, 0, "one_after");
    add(1, 1, 1, 0, 1, 0, "hold_e0");
    add(1, 1, 1, 1, 1, 0, "hold_e1");
    add(1, 1, 1, 1, 1, 0, "hold_e2");
    add(1, 1, 1, 1, 1, 0, "hold_e3");
    add(1, 1, 0, 1, 0, 0, "hold_e4");
    add(1, 1, 0, 0, 0, 0, "hold_after");

    foreach (tbl[i]) step(tbl[i].sel, tbl[i].rst, tbl[i].st, tbl[i].ed, tbl[i].eb, tbl[i].er, tbl[i].tag);

    // Reset mid-count must clear outputs without a clock edge
    step(0, 1, 1, 0, 1, 7, "mid_k");
    step(0, 1, 0, 0, 1, 6, "mid_k1");
    step(0, 1, 0, 0, 1, 5, "mid_k2");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 0, "mid_async_clear");
    compare_head();
    step(0, 0, 1, 0, 0, 0, "start_in_reset");
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, "no_done_after_rst");

    // Fresh start after release: done expected exactly 8 edges later
    step(0, 1, 1, 0, 1, 7, "restart_j");
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      start8 = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done8) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 8) begin
      errors++;
      $display("FAIL restart_latency: got done after %0d edges (seen=%0b), want 8", n, seen);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
